// File: rtl/snake_pkg.sv
// Shared encodings for the Snake step controller: keyboard move codes,
// direction and game-state types, plus small decode helpers.
package snake_pkg;

  localparam logic [2:0] MV_NONE  = 3'd0;
  localparam logic [2:0] MV_UP    = 3'd1;
  localparam logic [2:0] MV_DOWN  = 3'd2;
  localparam logic [2:0] MV_LEFT  = 3'd3;
  localparam logic [2:0] MV_RIGHT = 3'd4;
  localparam logic [2:0] MV_START = 3'd5;
  localparam logic [2:0] MV_PAUSE = 3'd6;
  localparam logic [2:0] MV_NOP   = 3'd7;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  // Externally visible game state; WAIT reports as RUN.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DEAD  = 2'd3
  } state_code_e;

  typedef enum logic [2:0] {
    FSM_IDLE,
    FSM_RUN,
    FSM_WAIT,
    FSM_PAUSE,
    FSM_DEAD
  } fsm_e;

  // Encoding is chosen so that the reverse direction differs only in bit 1.
  function automatic dir_e dir_opposite(input dir_e d);
    return dir_e'(d ^ 2'b10);
  endfunction

  function automatic logic is_dir_key(input logic [2:0] m);
    return (m == MV_UP) || (m == MV_DOWN) || (m == MV_LEFT) || (m == MV_RIGHT);
  endfunction

  function automatic dir_e key_to_dir(input logic [2:0] m);
    dir_e d;
    case (m)
      MV_UP:   d = DIR_UP;
      MV_DOWN: d = DIR_DOWN;
      MV_LEFT: d = DIR_LEFT;
      default: d = DIR_RIGHT;
    endcase
    return d;
  endfunction

  function automatic state_code_e state_code(input fsm_e f);
    state_code_e s;
    case (f)
      FSM_RUN, FSM_WAIT: s = ST_RUN;
      FSM_PAUSE:         s = ST_PAUSE;
      FSM_DEAD:          s = ST_DEAD;
      default:           s = ST_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dir_queue.sv
// Two-entry direction FIFO. Candidates equal to, or the reverse of, the
// newest queued direction (or the live direction when empty) are dropped.
module dir_queue
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush_i,
  input  logic       push_i,
  input  logic [1:0] cand_i,
  input  logic       pop_i,
  input  logic [1:0] cur_dir_i,
  output logic [1:0] head_o,
  output logic       nonempty_o
);

  dir_e       q0_q, q1_q;
  logic [1:0] cnt_q;

  dir_e cand;
  dir_e tail;
  logic do_pop;
  logic do_push;

  assign cand = dir_e'(cand_i);

  always_comb begin
    tail = dir_e'(cur_dir_i);
    if (cnt_q == 2'd1) tail = q0_q;
    else if (cnt_q == 2'd2) tail = q1_q;
  end

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  // A full queue still takes a candidate when the head leaves in the same cycle.
  assign do_push = push_i && (cand != tail) && (cand != dir_opposite(tail))
                   && ((cnt_q != 2'd2) || do_pop);

  assign head_o     = q0_q;
  assign nonempty_o = (cnt_q != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0_q  <= DIR_UP;
      q1_q  <= DIR_UP;
      cnt_q <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt_q == 2'd0) q0_q <= cand;
          else               q1_q <= cand;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          q0_q  <= q1_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            q0_q <= cand;
          end else begin
            q0_q <= q1_q;
            q1_q <= cand;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/snake_step_ctrl.sv
// Snake game sequencer: key-event filtering, frame-paced step requests,
// start/pause/dead state machine, score and speed-up bookkeeping.
module snake_step_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned FRAMES_PER_STEP = 8,
  parameter int unsigned MIN_FRAMES      = 2,
  parameter int unsigned SPEEDUP_EVERY   = 4,
  parameter int unsigned SCORE_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         move,
  input  logic               frame_tick,
  input  logic               step_done,
  input  logic               collide,
  input  logic               ate,
  output logic               step,
  output logic [1:0]         dir,
  output logic               grow,
  output logic               clear,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score
);

  localparam int unsigned CNT_W = $clog2(FRAMES_PER_STEP + 1);
  localparam int unsigned APL_W = (SPEEDUP_EVERY > 1) ? $clog2(SPEEDUP_EVERY) : 1;

  localparam logic [CNT_W-1:0] PER_INIT = CNT_W'(FRAMES_PER_STEP);
  localparam logic [CNT_W-1:0] PER_MIN  = CNT_W'(MIN_FRAMES);
  localparam logic [APL_W-1:0] APL_LAST = APL_W'(SPEEDUP_EVERY - 1);

  logic [2:0]         move_q;
  fsm_e               fsm_q;
  state_code_e        state_q;
  dir_e               dir_q;
  logic               step_q;
  logic               grow_q;
  logic               clear_q;
  logic [SCORE_W-1:0] score_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   period_q;
  logic [APL_W-1:0]   apl_q;
  logic               grow_pend_q;
  logic               pause_pend_q;

  logic             key_ev;
  logic             ev_start;
  logic             ev_pause;
  logic             ev_dir;
  logic [CNT_W-1:0] cnt_inc;
  logic             fire;
  logic             q_push;
  logic             q_flush;
  logic [1:0]       q_head;
  logic             q_nonempty;

  // Edge-detect on the level-coded key so a held key yields a single event.
  assign key_ev   = (move != move_q) && (move != MV_NONE) && (move != MV_NOP);
  assign ev_start = key_ev && (move == MV_START);
  assign ev_pause = key_ev && (move == MV_PAUSE);
  assign ev_dir   = key_ev && is_dir_key(move);

  assign cnt_inc = cnt_q + 1'b1;
  // A pause key arriving on the completing frame takes priority over the step.
  assign fire    = (fsm_q == FSM_RUN) && frame_tick && !ev_pause && (cnt_inc >= period_q);
  assign q_push  = ev_dir && ((fsm_q == FSM_RUN) || (fsm_q == FSM_WAIT));
  assign q_flush = ev_start && ((fsm_q == FSM_IDLE) || (fsm_q == FSM_DEAD));

  dir_queue u_dir_queue (
    .clk        (clk),
    .rst_n      (rst),
    .flush_i    (q_flush),
    .push_i     (q_push),
    .cand_i     (key_to_dir(move)),
    .pop_i      (fire),
    .cur_dir_i  (dir_q),
    .head_o     (q_head),
    .nonempty_o (q_nonempty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      move_q       <= MV_NONE;
      fsm_q        <= FSM_IDLE;
      state_q      <= ST_IDLE;
      dir_q        <= DIR_RIGHT;
      step_q       <= 1'b0;
      grow_q       <= 1'b0;
      clear_q      <= 1'b0;
      score_q      <= '0;
      cnt_q        <= '0;
      period_q     <= PER_INIT;
      apl_q        <= '0;
      grow_pend_q  <= 1'b0;
      pause_pend_q <= 1'b0;
    end else begin
      move_q  <= move;
      step_q  <= 1'b0;
      grow_q  <= 1'b0;
      clear_q <= 1'b0;

      case (fsm_q)
        FSM_IDLE, FSM_DEAD: begin
          if (ev_start) begin
            clear_q      <= 1'b1;
            score_q      <= '0;
            dir_q        <= DIR_RIGHT;
            period_q     <= PER_INIT;
            cnt_q        <= '0;
            apl_q        <= '0;
            grow_pend_q  <= 1'b0;
            pause_pend_q <= 1'b0;
            fsm_q        <= FSM_RUN;
            state_q      <= state_code(FSM_RUN);
          end
        end

        FSM_RUN: begin
          if (ev_pause) begin
            fsm_q   <= FSM_PAUSE;
            state_q <= state_code(FSM_PAUSE);
          end else if (fire) begin
            if (q_nonempty) dir_q <= dir_e'(q_head);
            step_q      <= 1'b1;
            grow_q      <= grow_pend_q;
            grow_pend_q <= 1'b0;
            cnt_q       <= '0;
            fsm_q       <= FSM_WAIT;
            state_q     <= state_code(FSM_WAIT);
          end else if (frame_tick) begin
            cnt_q <= cnt_inc;
          end
        end

        FSM_WAIT: begin
          if (step_done) begin
            pause_pend_q <= 1'b0;
            if (collide) begin
              fsm_q   <= FSM_DEAD;
              state_q <= state_code(FSM_DEAD);
            end else begin
              if (ate) begin
                if (score_q != '1) score_q <= score_q + 1'b1;
                grow_pend_q <= 1'b1;
                if (apl_q == APL_LAST) begin
                  apl_q <= '0;
                  if (period_q > PER_MIN) period_q <= period_q - 1'b1;
                end else begin
                  apl_q <= apl_q + 1'b1;
                end
              end
              if (pause_pend_q || ev_pause) begin
                fsm_q   <= FSM_PAUSE;
                state_q <= state_code(FSM_PAUSE);
              end else begin
                fsm_q   <= FSM_RUN;
                state_q <= state_code(FSM_RUN);
              end
            end
          end else if (ev_pause) begin
            pause_pend_q <= 1'b1;
          end
        end

        FSM_PAUSE: begin
          if (ev_pause) begin
            fsm_q   <= FSM_RUN;
            state_q <= state_code(FSM_RUN);
          end
        end

        default: begin
          fsm_q   <= FSM_IDLE;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign step  = step_q;
  assign dir   = dir_q;
  assign grow  = grow_q;
  assign clear = clear_q;
  assign state = state_q;
  assign score = score_q;

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Directed bench for snake_step_ctrl: stimulus applied and outputs sampled
// on the falling clock edge, expected values worked out by hand.
module tb_snake_step_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] move;
  logic       frame_tick;
  logic       step_done;
  logic       collide;
  logic       ate;
  logic       step;
  logic [1:0] dir;
  logic       grow;
  logic       clear;
  logic [1:0] state;
  logic [7:0] score;

  int n_checks = 0;
  int n_fail   = 0;

  always #20 clk = ~clk;

  snake_step_ctrl #(
    .FRAMES_PER_STEP (8),
    .MIN_FRAMES      (2),
    .SPEEDUP_EVERY   (4),
    .SCORE_W         (8)
  ) dut (
    .clk        (clk),
    .rst        (rst_n),
    .move       (move),
    .frame_tick (frame_tick),
    .step_done  (step_done),
    .collide    (collide),
    .ate        (ate),
    .step       (step),
    .dir        (dir),
    .grow       (grow),
    .clear      (clear),
    .state      (state),
    .score      (score)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic key(input logic [2:0] code);
    move = code;
    @(negedge clk);
    move = 3'd0;
    @(negedge clk);
  endtask

  task automatic done(input logic c, input logic a);
    step_done = 1'b1;
    collide   = c;
    ate       = a;
    @(negedge clk);
    step_done = 1'b0;
    collide   = 1'b0;
    ate       = 1'b0;
  endtask

  // Back-to-back frame ticks until a step appears (bounded), then check timing.
  task automatic ticks_to_step(input int exp_ticks, input int exp_dir,
                               input int exp_grow, input string tag);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      n++;
      seen = step;
    end
    check_eq({tag, "_ticks"}, n, exp_ticks);
    check_eq({tag, "_dir"}, 32'(dir), exp_dir);
    check_eq({tag, "_grow"}, 32'(grow), exp_grow);
  endtask

  task automatic ticks_no_step(input int n_ticks, input string tag);
    int steps;
    steps = 0;
    for (int i = 0; i < n_ticks; i++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      if (step) steps++;
    end
    check_eq({tag, "_steps"}, steps, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    rst_n = 1'b0; move = 3'd0; frame_tick = 1'b0;
    step_done = 1'b0; collide = 1'b0; ate = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_step",  32'(step),  0);
    check_eq("rst_grow",  32'(grow),  0);
    check_eq("rst_clear", 32'(clear), 0);
    check_eq("rst_dir",   32'(dir),   1);
    check_eq("rst_state", 32'(state), 0);
    check_eq("rst_score", 32'(score), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Start: clear pulse and RUN one cycle after the event
    move = 3'd5;
    @(negedge clk);
    check_eq("start_clear", 32'(clear), 1);
    check_eq("start_state", 32'(state), 1);
    move = 3'd0;
    @(negedge clk);
    check_eq("start_clear_off", 32'(clear), 0);
    ticks_to_step(8, 1, 0, "first");
    done(1'b0, 1'b0);
    check_eq("first_state", 32'(state), 1);
    check_eq("first_score", 32'(score), 0);

    // Filter: left reversed, up queued, left queued, down dropped (full)
    key(3'd3); key(3'd1); key(3'd3); key(3'd2);
    ticks_to_step(8, 0, 0, "filt1"); done(1'b0, 1'b0);
    ticks_to_step(8, 3, 0, "filt2"); done(1'b0, 1'b0);
    ticks_to_step(8, 3, 0, "filt3"); done(1'b0, 1'b0);

    // Full queue (up,right) takes down on the same cycle as a pop
    key(3'd1); key(3'd4);
    repeat (7) begin
      frame_tick = 1'b1;
      @(negedge clk);
    end
    move = 3'd2;
    @(negedge clk);
    frame_tick = 1'b0;
    move = 3'd0;
    check_eq("pp_step", 32'(step), 1);
    check_eq("pp_dir",  32'(dir),  0);
    done(1'b0, 1'b0);
    ticks_to_step(8, 1, 0, "pp2"); done(1'b0, 1'b0);
    ticks_to_step(8, 2, 0, "pp3");

    // Four apples: score 4, grow carried, period 8 -> 7
    for (int i = 0; i < 4; i++) begin
      if (i > 0) ticks_to_step(8, 2, 1, "apl");
      done(1'b0, 1'b1);
    end
    check_eq("apl4_score", 32'(score), 4);
    ticks_to_step(7, 2, 1, "per7a"); done(1'b0, 1'b0);
    ticks_to_step(7, 2, 0, "per7b");

    // Apples 5..28: period floors at 2 after the 24th
    for (int k = 5; k <= 28; k++) begin
      done(1'b0, 1'b1);
      p = 8 - k / 4;
      if (p < 2) p = 2;
      ticks_to_step(p, 2, 1, $sformatf("spd%0d", k));
    end
    check_eq("spd_score", 32'(score), 28);

    // Collide wins over ate; restart clears score
    done(1'b1, 1'b1);
    check_eq("dead_state", 32'(state), 3);
    check_eq("dead_score", 32'(score), 28);
    ticks_no_step(10, "dead");
    move = 3'd5;
    @(negedge clk);
    check_eq("restart_clear", 32'(clear), 1);
    check_eq("restart_state", 32'(state), 1);
    check_eq("restart_score", 32'(score), 0);
    check_eq("restart_dir",   32'(dir),   1);
    move = 3'd0;
    @(negedge clk);
    ticks_to_step(8, 1, 0, "restart");

    // Pause latched during WAIT, then pause mid-count and resume
    key(3'd6);
    check_eq("wpause_state", 32'(state), 1);
    done(1'b0, 1'b0);
    check_eq("paused_state", 32'(state), 2);
    ticks_no_step(20, "paused");
    key(3'd6);
    check_eq("resume_state", 32'(state), 1);
    ticks_no_step(3, "pre");
    key(3'd6);
    check_eq("pause2_state", 32'(state), 2);
    ticks_no_step(20, "paused2");
    key(3'd6);
    ticks_to_step(5, 1, 0, "resume");
    done(1'b0, 1'b1);
    ticks_to_step(8, 1, 1, "prerst");

    // Asynchronous reset with a step in flight
    #5;
    rst_n = 1'b0;
    #5;
    check_eq("arst_step",  32'(step),  0);
    check_eq("arst_grow",  32'(grow),  0);
    check_eq("arst_dir",   32'(dir),   1);
    check_eq("arst_state", 32'(state), 0);
    check_eq("arst_score", 32'(score), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    key(3'd5);
    ticks_to_step(8, 1, 0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
